// File: rtl/noc_router_node.sv
// Five-port mesh router node: per-input FIFOs, dimension-ordered routing,
// wormhole output locking with round-robin grant and a registered output stage.
module noc_router_node #(
  parameter int FLIT_W     = 64,
  parameter int DEPTH      = 4,
  parameter int COORD_W    = 2,
  parameter int X_POS      = 0,
  parameter int Y_POS      = 0,
  parameter int ROUTE_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*FLIT_W-1:0] flit_in,
  input  logic [4:0]          valid_in,
  output logic [4:0]          ready_out,
  output logic [5*FLIT_W-1:0] flit_out,
  output logic [4:0]          valid_out,
  input  logic [4:0]          ready_in
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_POS);
  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_S = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  logic [FLIT_W-1:0] head_flit [5];
  logic [2:0]        route     [5];
  logic [4:0]        not_empty;
  logic [4:0]        pop;
  logic [4:0]        xfer_v;
  logic [2:0]        sel_v     [5];

  function automatic logic [2:0] route_of(input logic [2*COORD_W-1:0] dest);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         xdir;
    logic [2:0]         ydir;
    dx   = dest[COORD_W-1:0];
    dy   = dest[2*COORD_W-1:COORD_W];
    xdir = (dx > X_C) ? P_E : P_W;
    ydir = (dy > Y_C) ? P_S : P_N;
    if (ROUTE_MODE == 0)
      route_of = (dx != X_C) ? xdir : ((dy != Y_C) ? ydir : P_L);
    else
      route_of = (dy != Y_C) ? ydir : ((dx != X_C) ? xdir : P_L);
  endfunction

  genvar gi;

  // Input FIFOs: asynchronous head read so routing and transfer happen the
  // cycle after the write edge.
  for (gi = 0; gi < 5; gi++) begin : g_in
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push;

    assign ready_out[gi] = !rst && (count_reg != CNT_W'(DEPTH));
    assign push          = valid_in[gi] && ready_out[gi];

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr_reg] <= flit_in[gi*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop[gi])
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop[gi]);
      end
    end

    assign head_flit[gi] = mem[rd_ptr_reg];
    assign not_empty[gi] = (count_reg != '0);
    assign route[gi]     = route_of(head_flit[gi][2*COORD_W-1:0]);
  end

  // Output stages: lock/owner, round-robin arbitration and output register.
  for (gi = 0; gi < 5; gi++) begin : g_out
    logic [2:0]        owner_reg;
    logic [2:0]        rr_ptr_reg;
    logic              locked_reg;
    logic              valid_reg;
    logic [FLIT_W-1:0] flit_reg;
    logic [4:0]        req;
    logic [2:0]        grant;
    logic              found;
    logic [2:0]        sel;
    logic              sel_ok;
    logic              stage_free;
    logic              xfer;
    logic [FLIT_W-1:0] sel_flit;
    logic [3:0]        idx;

    always_comb begin
      for (int i = 0; i < 5; i++)
        req[i] = not_empty[i] && head_flit[i][FLIT_W-1] && (route[i] == 3'(gi));
    end

    always_comb begin
      found = 1'b0;
      grant = 3'd0;
      idx   = 4'd0;
      for (int k = 0; k < 5; k++) begin
        idx = {1'b0, rr_ptr_reg} + 4'(k);
        if (idx > 4'd4)
          idx = idx - 4'd5;
        if (!found && req[idx[2:0]]) begin
          found = 1'b1;
          grant = idx[2:0];
        end
      end
    end

    assign sel        = locked_reg ? owner_reg : grant;
    assign sel_ok     = locked_reg ? not_empty[owner_reg] : found;
    assign stage_free = !valid_reg || ready_in[gi];
    assign xfer       = stage_free && sel_ok;
    assign sel_flit   = head_flit[sel];

    always_ff @(posedge clk) begin
      if (rst) begin
        owner_reg  <= 3'd0;
        rr_ptr_reg <= 3'd0;
        locked_reg <= 1'b0;
        valid_reg  <= 1'b0;
        flit_reg   <= '0;
      end else begin
        if (stage_free) begin
          valid_reg <= xfer;
          if (xfer)
            flit_reg <= sel_flit;
        end
        if (xfer) begin
          if (!locked_reg) begin
            owner_reg  <= grant;
            rr_ptr_reg <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
            locked_reg <= !sel_flit[FLIT_W-2];
          end else if (sel_flit[FLIT_W-2]) begin
            locked_reg <= 1'b0;
          end
        end
      end
    end

    assign flit_out[gi*FLIT_W +: FLIT_W] = flit_reg;
    assign valid_out[gi]                 = valid_reg;
    assign xfer_v[gi]                    = xfer;
    assign sel_v[gi]                     = sel;
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < 5; o++)
      for (int i = 0; i < 5; i++)
        if (xfer_v[o] && (sel_v[o] == 3'(i)))
          pop[i] = 1'b1;
  end

endmodule

// File: tb/tb_noc_router_node.sv
// Directed bench for noc_router_node at node (1,1): reset, routing in both
// modes, wormhole arbitration, backpressure and mid-packet reset.
module tb_noc_router_node;
  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [5*FW-1:0] flit_in;
  logic [4:0]    valid_in;
  logic [4:0]    ready_in;
  logic [4:0]    ready_out;
  logic [5*FW-1:0] flit_out;
  logic [4:0]    valid_out;
  logic [4:0]    ready_out_yx;
  logic [5*FW-1:0] flit_out_yx;
  logic [4:0]    valid_out_yx;

  int checks   = 0;
  int failures = 0;
  int sent;
  int rcv;

  noc_router_node #(.FLIT_W(FW), .DEPTH(4), .COORD_W(2), .X_POS(1), .Y_POS(1), .ROUTE_MODE(0)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out),
    .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  noc_router_node #(.FLIT_W(FW), .DEPTH(4), .COORD_W(2), .X_POS(1), .Y_POS(1), .ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out_yx),
    .flit_out(flit_out_yx), .valid_out(valid_out_yx), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {HEAD, TAIL, zeros, tag, dest Y, dest X}
  function automatic logic [63:0] mk(input logic h, input logic t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [7:0] tag);
    return {h, t, 50'd0, tag, dy, dx};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst      = 1'b1;
    valid_in = '0;
    flit_in  = '0;
    ready_in = 5'h1f;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    valid_in = '0;
    flit_in  = '0;
    ready_in = 5'h1f;
    tick;
    tick;
    checks++;
    if (valid_out !== 5'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected %b", valid_out, 5'b0);
    end
    checks++;
    if (ready_out !== 5'b0) begin
      failures++;
      $display("FAIL reset_ready_low: got %b expected %b", ready_out, 5'b0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_out !== 5'b11111) begin
      failures++;
      $display("FAIL reset_ready_high: got %b expected %b", ready_out, 5'b11111);
    end
    checks++;
    if (flit_out !== '0) begin
      failures++;
      $display("FAIL reset_flit_out: got %h expected 0", flit_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_flit;
    logic [63:0] f;
    f = 64'hC000_0000_0000_0007;  // HEAD|TAIL, dest (3,1)
    apply_reset;
    flit_in[4*FW +: FW] = f;
    valid_in = 5'b10000;
    tick;
    valid_in = '0;
    checks++;
    if (valid_out !== 5'b0) begin
      failures++;
      $display("FAIL single_cycle1_valid: got %b expected %b", valid_out, 5'b0);
    end
    tick;
    checks++;
    if (valid_out !== 5'b00010) begin
      failures++;
      $display("FAIL single_cycle2_valid: got %b expected %b", valid_out, 5'b00010);
    end
    checks++;
    if (flit_out[1*FW +: FW] !== f) begin
      failures++;
      $display("FAIL single_data: got %h expected %h", flit_out[1*FW +: FW], f);
    end
    tick;
    checks++;
    if (valid_out !== 5'b0) begin
      failures++;
      $display("FAIL single_cycle3_valid: got %b expected %b", valid_out, 5'b0);
    end
    $display("test_single_flit done");
  endtask

  task automatic test_route_mode;
    logic [63:0] g;
    g = mk(1'b1, 1'b1, 2'd2, 2'd3, 8'h5A);  // dest (2,3)
    apply_reset;
    flit_in[4*FW +: FW] = g;
    valid_in = 5'b10000;
    tick;
    valid_in = '0;
    tick;
    checks++;
    if (valid_out !== 5'b00010) begin
      failures++;
      $display("FAIL route_xy_valid: got %b expected %b", valid_out, 5'b00010);
    end
    checks++;
    if (flit_out[1*FW +: FW] !== g) begin
      failures++;
      $display("FAIL route_xy_data: got %h expected %h", flit_out[1*FW +: FW], g);
    end
    checks++;
    if (valid_out_yx !== 5'b00100) begin
      failures++;
      $display("FAIL route_yx_valid: got %b expected %b", valid_out_yx, 5'b00100);
    end
    checks++;
    if (flit_out_yx[2*FW +: FW] !== g) begin
      failures++;
      $display("FAIL route_yx_data: got %h expected %h", flit_out_yx[2*FW +: FW], g);
    end
    $display("test_route_mode done");
  endtask

  task automatic test_arbitration;
    logic [63:0] nf [3];
    logic [63:0] wf [3];
    logic [63:0] exp_f;
    // body/tail coordinate fields hold junk that must not influence routing
    nf[0] = mk(1'b1, 1'b0, 2'd1, 2'd1, 8'h10);
    nf[1] = mk(1'b0, 1'b0, 2'd3, 2'd0, 8'h11);
    nf[2] = mk(1'b0, 1'b1, 2'd0, 2'd2, 8'h12);
    wf[0] = mk(1'b1, 1'b0, 2'd1, 2'd1, 8'h30);
    wf[1] = mk(1'b0, 1'b0, 2'd2, 2'd3, 8'h31);
    wf[2] = mk(1'b0, 1'b1, 2'd3, 2'd3, 8'h32);
    apply_reset;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        flit_in[0*FW +: FW] = nf[c];
        flit_in[3*FW +: FW] = wf[c];
        valid_in = 5'b01001;
      end else begin
        valid_in = '0;
      end
      if (c >= 2) begin
        exp_f = (c < 5) ? nf[c-2] : wf[c-5];
        checks++;
        if (valid_out !== 5'b10000) begin
          failures++;
          $display("FAIL arb_valid_c%0d: got %b expected %b", c, valid_out, 5'b10000);
        end
        checks++;
        if (flit_out[4*FW +: FW] !== exp_f) begin
          failures++;
          $display("FAIL arb_data_c%0d: got %h expected %h", c, flit_out[4*FW +: FW], exp_f);
        end
      end
      tick;
    end
    $display("test_arbitration done");
  endtask

  task automatic test_backpressure;
    logic [63:0] bp [8];
    for (int k = 0; k < 8; k++)
      bp[k] = mk(1'b1, 1'b1, 2'd3, 2'd1, 8'(8'h40 + k));
    apply_reset;
    ready_in = 5'b11101;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      if (sent >= 8) break;
      flit_in[4*FW +: FW] = bp[sent];
      valid_in = 5'b10000;
      if (!ready_out[4]) break;
      sent++;
      tick;
    end
    checks++;
    if (sent !== 5) begin
      failures++;
      $display("FAIL bp_accepted: got %0d expected %0d", sent, 5);
    end
    checks++;
    if (ready_out[4] !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_drop: got %b expected %b", ready_out[4], 1'b0);
    end
    checks++;
    if (valid_out[1] !== 1'b1 || flit_out[1*FW +: FW] !== bp[0]) begin
      failures++;
      $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=%h",
               valid_out[1], flit_out[1*FW +: FW], bp[0]);
    end
    ready_in = 5'h1f;
    rcv = 0;
    for (int c = 0; c < 30; c++) begin
      if (sent < 8) begin
        flit_in[4*FW +: FW] = bp[sent];
        valid_in = 5'b10000;
        if (ready_out[4]) sent++;
      end else begin
        valid_in = '0;
      end
      if (valid_out[1]) begin
        checks++;
        if (rcv >= 8) begin
          failures++;
          $display("FAIL bp_extra_flit: got %h expected no flit", flit_out[1*FW +: FW]);
        end else if (flit_out[1*FW +: FW] !== bp[rcv]) begin
          failures++;
          $display("FAIL bp_order_%0d: got %h expected %h", rcv, flit_out[1*FW +: FW], bp[rcv]);
        end
        rcv++;
      end
      tick;
    end
    checks++;
    if (rcv !== 8) begin
      failures++;
      $display("FAIL bp_received: got %0d expected %0d", rcv, 8);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_packet;
    logic [63:0] f;
    apply_reset;
    flit_in[4*FW +: FW] = mk(1'b1, 1'b0, 2'd3, 2'd1, 8'h70);
    valid_in = 5'b10000;
    tick;
    flit_in[4*FW +: FW] = mk(1'b0, 1'b0, 2'd0, 2'd0, 8'h71);
    rst = 1'b1;
    tick;
    checks++;
    if (valid_out !== 5'b0) begin
      failures++;
      $display("FAIL midrst_valid: got %b expected %b", valid_out, 5'b0);
    end
    rst      = 1'b0;
    valid_in = '0;
    #1;
    // a stale lock on E held by Local would block this N-port head
    f = mk(1'b1, 1'b1, 2'd3, 2'd1, 8'h7F);
    flit_in[0*FW +: FW] = f;
    valid_in = 5'b00001;
    tick;
    valid_in = '0;
    checks++;
    if (valid_out !== 5'b0) begin
      failures++;
      $display("FAIL midrst_no_leak: got %b expected %b", valid_out, 5'b0);
    end
    tick;
    checks++;
    if (valid_out !== 5'b00010) begin
      failures++;
      $display("FAIL midrst_fresh_valid: got %b expected %b", valid_out, 5'b00010);
    end
    checks++;
    if (flit_out[1*FW +: FW] !== f) begin
      failures++;
      $display("FAIL midrst_fresh_data: got %h expected %h", flit_out[1*FW +: FW], f);
    end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = '0;
    flit_in  = '0;
    ready_in = 5'h1f;
    test_reset;
    test_single_flit;
    test_route_mode;
    test_arbitration;
    test_backpressure;
    test_reset_mid_packet;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
